// File: rtl/freq_gen.sv
// freq_gen: programmable pulse-train generator, F rising edges per WINDOW-cycle gate
module freq_gen #(
    parameter int WINDOW = 250,
    parameter int FW     = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [FW-1:0] freq_in,
    output logic          wave,
    output logic          tick,
    output logic          win_start,
    output logic [FW-1:0] edge_cnt,
    output logic [FW-1:0] last_cnt,
    output logic          done
);
    localparam int CW = $clog2(WINDOW);
    localparam int AW = $clog2(WINDOW + 127);
    typedef enum logic {IDLE, RUN} state_t;
    state_t        r_state, w_next;
    logic [CW-1:0] r_win_cnt;
    logic [AW-1:0] r_acc, w_sum;
    logic [FW-1:0] r_freq, r_edge, r_last;
    logic          r_wave, r_tick, r_ws, r_done;
    logic          w_ovf, w_rise, w_last;
    // next state plus phase accumulator arithmetic; one overflow at most per cycle
    always_comb begin
        w_next = en ? RUN : IDLE;
        w_sum  = r_acc + AW'({r_freq, 1'b0});
        w_ovf  = w_sum >= AW'(WINDOW);
        w_rise = w_ovf && !r_wave;
        w_last = r_win_cnt == CW'(WINDOW - 1);
    end
    // state register; reset dominates en
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    // datapath: window counter, accumulator, wave and edge bookkeeping
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            r_win_cnt <= '0;
            r_acc     <= '0;
            r_wave    <= 1'b0;
            r_tick    <= 1'b0;
            r_edge    <= '0;
            r_ws      <= 1'b0;
            r_done    <= 1'b0;
            if (reset) begin
                r_last <= '0;
                r_freq <= '0;
            end
        end else if (r_state == IDLE) begin
            r_freq    <= freq_in;
            r_win_cnt <= '0;
            r_acc     <= '0;
            r_wave    <= 1'b0;
            r_tick    <= 1'b0;
            r_edge    <= '0;
            r_ws      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_acc     <= w_ovf ? w_sum - AW'(WINDOW) : w_sum;
            r_wave    <= r_wave ^ w_ovf;
            r_tick    <= w_rise;
            r_done    <= w_last;
            r_ws      <= w_last;
            r_win_cnt <= w_last ? '0 : r_win_cnt + CW'(1);
            r_edge    <= w_last ? '0 : r_edge + FW'(w_rise);
            if (w_last) begin
                r_last <= r_edge;
                r_freq <= freq_in;
            end
        end
    end
    assign wave      = r_wave;
    assign tick      = r_tick;
    assign win_start = r_ws;
    assign edge_cnt  = r_edge;
    assign last_cnt  = r_last;
    assign done      = r_done;
endmodule

// File: tb/tb_freq_gen.sv
// tb_freq_gen: scoreboard bench with closed-form expected wave/tick/edge counts
module tb_freq_gen;
    localparam int W  = 250;
    localparam int FW = 6;
    logic          clk = 1'b0;
    logic          reset, en;
    logic [FW-1:0] freq_in;
    logic          wave, tick, win_start, done;
    logic [FW-1:0] edge_cnt, last_cnt;
    typedef struct packed {
        logic          wave;
        logic          tick;
        logic          ws;
        logic [FW-1:0] ec;
        logic [FW-1:0] lc;
        logic          done;
    } exp_t;
    exp_t q[$];
    int   checks = 0, passed = 0, fails = 0;
    bit   m_run = 1'b0;
    int   m_n = 0, m_f = 0, m_last = 0;
    int   ticks_seen = 0, last_tick = -1, cyc = 0;
    logic prev_tick = 1'b0;

    freq_gen #(.WINDOW(W), .FW(FW)) dut (
        .clk(clk), .reset(reset), .en(en), .freq_in(freq_in),
        .wave(wave), .tick(tick), .win_start(win_start),
        .edge_cnt(edge_cnt), .last_cnt(last_cnt), .done(done)
    );

    always #5 clk = ~clk;

    // expected outputs after the coming edge: toggles so far = floor(2F*n/W)
    function automatic exp_t model(bit r, bit e, int f);
        exp_t x;
        int   k, kp;
        x = '0;
        if (r) begin
            m_run  = 1'b0;
            m_last = 0;
        end else if (!e) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_f   = f;
            m_n   = 0;
            x.ws  = 1'b1;
        end else if (m_n == W - 1) begin
            m_last = m_f;
            x.done = 1'b1;
            x.ws   = 1'b1;
            m_f    = f;
            m_n    = 0;
        end else begin
            m_n++;
            k      = 2 * m_f * m_n / W;
            kp     = 2 * m_f * (m_n - 1) / W;
            x.wave = k[0];
            x.tick = k[0] && (k != kp);
            x.ec   = FW'((k + 1) / 2);
        end
        x.lc = FW'(m_last);
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        exp_t e;
        q.push_back(model(reset, en, int'(freq_in)));
        @(posedge clk);
        #1;
        cyc++;
        e = q.pop_front();
        chk("wave", 32'(wave), 32'(e.wave));
        chk("tick", 32'(tick), 32'(e.tick));
        chk("win_start", 32'(win_start), 32'(e.ws));
        chk("edge_cnt", 32'(edge_cnt), 32'(e.ec));
        chk("last_cnt", 32'(last_cnt), 32'(e.lc));
        chk("done", 32'(done), 32'(e.done));
        if (done) chk("window_ticks", 32'(ticks_seen), 32'(e.lc));
        if (win_start || !m_run) ticks_seen = 0;
        if (m_f != 63) last_tick = -1;
        if (tick) begin
            ticks_seen++;
            chk("tick_gap", 32'(prev_tick), 32'(0));
            if (last_tick >= 0)
                chk("tick_spacing", 32'((cyc - last_tick >= 3) && (cyc - last_tick <= 4)), 32'(1));
            last_tick = cyc;
        end
        prev_tick = tick;
    endtask

    task automatic windows(input int k);
        for (int w = 0; w < k; w++) begin
            int i = 0;
            do begin
                step();
                i++;
            end while (!done && i < W + 5);
            chk("window_done", 32'(done), 32'(1));
        end
    endtask

    task automatic to_idx(input int idx);
        for (int i = 0; i < 2 * W && !(m_run && m_n == idx); i++) step();
    endtask

    initial begin
        reset   = 1'b1;
        en      = 1'b1;
        freq_in = 6'd1;
        repeat (5) step();
        reset = 1'b0;
        windows(2);
        freq_in = 6'd63;
        windows(3);
        freq_in = 6'd10;
        windows(1);
        to_idx(100);
        freq_in = 6'd20;
        windows(2);
        freq_in = 6'd40;
        windows(1);
        to_idx(150);
        en = 1'b0;
        repeat (4) step();
        en = 1'b1;
        step();
        to_idx(80);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        windows(1);
        freq_in = 6'd0;
        windows(3);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
